// File: rtl/fft_bitrev_loader.sv
// fft_bitrev_loader: radix-2 DIT FFT input stage.
// Collects N complex samples in natural order into bit-reversed addresses,
// then streams adjacent-address operand pairs with twiddle W0 to the butterfly.
module fft_bitrev_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int EXPAND     = 6,
  parameter int LOG2N      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_real,
  input  logic [DATA_WIDTH-1:0]   in_imag,
  input  logic                    out_ready,
  output logic                    out_en,
  output logic [DATA_WIDTH-1:0]   in1_real,
  output logic [DATA_WIDTH-1:0]   in1_imag,
  output logic [DATA_WIDTH-1:0]   in2_real,
  output logic [DATA_WIDTH-1:0]   in2_imag,
  output logic [EXPAND+1:0]       ro_real,
  output logic [EXPAND+1:0]       ro_imag,
  output logic                    frame_done
);

  localparam int N = 1 << LOG2N;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t                      state;
  logic [LOG2N-1:0]            wcnt;
  logic [LOG2N-2:0]            pcnt;
  logic [2*DATA_WIDTH-1:0]     mem [N];
  logic [2*DATA_WIDTH-1:0]     word1;
  logic [2*DATA_WIDTH-1:0]     word2;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

  // Pair operands come from adjacent bit-reversed entries.
  assign word1 = mem[{pcnt, 1'b0}];
  assign word2 = mem[{pcnt, 1'b1}];

  // Frame control: fill counter, pair counter, state and end-of-frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      wcnt       <= '0;
      pcnt       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        FILL: begin
          if (in_valid) begin
            wcnt <= wcnt + LOG2N'(1);
            if (wcnt == '1) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            pcnt <= pcnt + (LOG2N-1)'(1);
            if (pcnt == '1) begin
              state      <= FILL;
              frame_done <= 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Sample storage at bit-reversed address; contents need no reset.
  always_ff @(posedge clk) begin
    if (state == FILL && in_valid) mem[bitrev(wcnt)] <= {in_real, in_imag};
  end

  // Outputs decode only registered state and memory; zeroed outside DRAIN.
  always_comb begin
    in_ready = (state == FILL);
    out_en   = (state == DRAIN);
    in1_real = '0;
    in1_imag = '0;
    in2_real = '0;
    in2_imag = '0;
    ro_real  = '0;
    ro_imag  = '0;
    if (state == DRAIN) begin
      {in1_real, in1_imag} = word1;
      {in2_real, in2_imag} = word2;
      ro_real              = (EXPAND+2)'(1) << EXPAND;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Self-checking bench for fft_bitrev_loader against a frame-level reference model.
module tb_fft_bitrev_loader;

  localparam int DW = 8;
  localparam int EX = 6;
  localparam int L  = 3;
  localparam int N  = 1 << L;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_real;
  logic [DW-1:0] in_imag;
  logic          out_ready;
  logic          out_en;
  logic [DW-1:0] in1_real;
  logic [DW-1:0] in1_imag;
  logic [DW-1:0] in2_real;
  logic [DW-1:0] in2_imag;
  logic [EX+1:0] ro_real;
  logic [EX+1:0] ro_imag;
  logic          frame_done;

  int total = 0;
  int bad   = 0;
  int sre[N];
  int sim[N];

  fft_bitrev_loader #(.DATA_WIDTH(DW), .EXPAND(EX), .LOG2N(L)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag),
    .out_ready(out_ready), .out_en(out_en),
    .in1_real(in1_real), .in1_imag(in1_imag),
    .in2_real(in2_real), .in2_imag(in2_imag),
    .ro_real(ro_real), .ro_imag(ro_imag),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Index reversal by repeated halving: sample index stored at address a.
  function automatic int rev_index(input int a);
    int r = 0;
    int x = a;
    for (int i = 0; i < L; i++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pair(input int p);
    int a = rev_index(2 * p);
    int b = rev_index(2 * p + 1);
    check("pair_en",    out_en, 1);
    check("in1_real",   $signed(in1_real), sre[a]);
    check("in1_imag",   $signed(in1_imag), sim[a]);
    check("in2_real",   $signed(in2_real), sre[b]);
    check("in2_imag",   $signed(in2_imag), sim[b]);
    check("ro_real",    $signed(ro_real), 1 << EX);
    check("ro_imag",    $signed(ro_imag), 0);
    check("ready_drain", in_ready, 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_en"}, out_en, 0);
    check({tag, "_in1_real"}, int'(in1_real), 0);
    check({tag, "_in2_imag"}, int'(in2_imag), 0);
    check({tag, "_ro_real"}, int'(ro_real), 0);
  endtask

  task automatic rand_frame();
    for (int k = 0; k < N; k++) begin
      sre[k] = int'($urandom_range(0, 255)) - 128;
      sim[k] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  // Offer nsamp samples; gap inserts an idle cycle before each one.
  task automatic fill(input bit gap, input int nsamp);
    for (int k = 0; k < nsamp; k++) begin
      if (gap) begin
        in_valid = 1'b0;
        step();
      end
      check("ready_fill", in_ready, 1);
      check("en_fill", out_en, 0);
      in_valid = 1'b1;
      in_real  = DW'(sre[k]);
      in_imag  = DW'(sim[k]);
      step();
    end
    in_valid = 1'b0;
    if (nsamp == N) begin
      check("ready_after_fill", in_ready, 0);
      check("en_after_fill", out_en, 1);
    end
  endtask

  // Accept npairs pairs; bp_pair is held for bp_cyc cycles; junk offers 99s.
  task automatic drain(input int bp_pair, input int bp_cyc, input bit junk, input int npairs);
    out_ready = 1'b1;
    if (junk) begin
      in_valid = 1'b1;
      in_real  = DW'(99);
      in_imag  = DW'(99);
    end
    for (int p = 0; p < npairs; p++) begin
      check_pair(p);
      check("done_mid", frame_done, 0);
      if (p == bp_pair) begin
        out_ready = 1'b0;
        for (int c = 0; c < bp_cyc; c++) begin
          step();
          check_pair(p);
        end
        out_ready = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    if (npairs == N / 2) begin
      check("done_pulse", frame_done, 1);
      check_idle("post_frame");
      step();
      check("done_clear", frame_done, 0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_real   = '0;
    in_imag   = '0;
    out_ready = 1'b1;
    step();
    step();
    check_idle("reset");
    check("reset_done", frame_done, 0);
    rst = 1'b0;
    step();

    // Basic ramp frame.
    for (int k = 0; k < N; k++) begin
      sre[k] = k + 1;
      sim[k] = -(k + 1);
    end
    fill(1'b0, N);
    drain(-1, 0, 1'b0, N / 2);

    // Same frame with backpressure on pair 1.
    fill(1'b0, N);
    drain(1, 3, 1'b0, N / 2);

    // Gapped input, random data.
    rand_frame();
    fill(1'b1, N);
    drain(-1, 0, 1'b0, N / 2);

    // Junk offered during drain must not land anywhere.
    rand_frame();
    fill(1'b0, N);
    drain(-1, 0, 1'b1, N / 2);
    rand_frame();
    fill(1'b0, N);
    drain(3, 2, 1'b0, N / 2);

    // Reset after a partial fill, then a fresh 10..17 frame.
    rand_frame();
    fill(1'b0, 5);
    rst = 1'b1;
    #1;
    check_idle("rst_fill");
    step();
    rst = 1'b0;
    step();
    for (int k = 0; k < N; k++) begin
      sre[k] = 10 + k;
      sim[k] = int'($urandom_range(0, 255)) - 128;
    end
    fill(1'b0, N);
    drain(-1, 0, 1'b0, N / 2);

    // Reset after two pairs of a drain: outputs clear without a clock edge.
    rand_frame();
    fill(1'b0, N);
    drain(-1, 0, 1'b0, 2);
    rst = 1'b1;
    #1;
    check_idle("rst_drain");
    check("rst_drain_done", frame_done, 0);
    step();
    rst = 1'b0;
    step();
    check("rst_drain_done2", frame_done, 0);
    check_idle("rst_drain2");

    // Randomized frames after recovery.
    for (int f = 0; f < 4; f++) begin
      rand_frame();
      fill(($urandom_range(0, 1) == 1), N);
      drain(int'($urandom_range(0, 4)), int'($urandom_range(1, 3)), ($urandom_range(0, 1) == 1), N / 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
